// File: rtl/kmeans_pkg.sv
// Shared types, defaults and the cold-seed x table for the k_means frame sequencer.
package kmeans_pkg;

    localparam int WIDTH_DEF  = 320;
    localparam int HEIGHT_DEF = 180;
    localparam int MAX_BALLS  = 7;
    localparam int XW         = 9;
    localparam int YW         = 8;
    localparam int NB_W       = 3;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        STORE,
        KICK,
        RUN
    } seq_state_t;

    typedef logic [MAX_BALLS-1:0][XW-1:0] xvec_t;
    typedef logic [MAX_BALLS-1:0][YW-1:0] yvec_t;
    typedef xvec_t [MAX_BALLS:0]          seed_lut_t;

    // Row n holds x = (2i+1)*width/(2n) for i < n; row 0 and entries i >= n stay 0.
    function automatic seed_lut_t build_seed_lut(input int width);
        seed_lut_t lut;
        lut = '0;
        for (int n = 1; n <= MAX_BALLS; n++) begin
            for (int i = 0; i < n; i++) begin
                lut[n][i] = XW'(((2 * i + 1) * width) / (2 * n));
            end
        end
        return lut;
    endfunction

    localparam seed_lut_t SEED_X_LUT = build_seed_lut(WIDTH_DEF);

endpackage

// File: rtl/kmeans_seed_rom.sv
// Cold-seed x lookup: active centroid count n -> evenly spaced x positions across the mask.
module kmeans_seed_rom
    import kmeans_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [NB_W-1:0] n_i,
    output xvec_t           cold_x_o
);

    localparam seed_lut_t LUT = build_seed_lut(WIDTH);

    always_comb begin
        cold_x_o = LUT[n_i];
    end

endmodule

// File: rtl/kmeans_frame_sequencer.sv
// Per-frame sequencer for the k_means centroid engine: seed, fill, kick, collect, warm-start.
// Optional RUN-state watchdog is compiled in with `define KMEANS_WATCHDOG_EN.
module kmeans_frame_sequencer
    import kmeans_pkg::*;
#(
    parameter int WIDTH          = WIDTH_DEF,
    parameter int HEIGHT         = HEIGHT_DEF,
    parameter int TIMEOUT_CYCLES = 131072,
    parameter int DROP_W         = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              enable_in,
    input  logic [NB_W-1:0]   num_balls_in,
    input  logic              frame_start_in,
    input  logic              frame_done_in,
    input  logic              km_valid_in,
    input  xvec_t             km_x_in,
    input  yvec_t             km_y_in,
    output logic              km_rst_out,
    output logic              km_new_frame_out,
    output xvec_t             seed_x_out,
    output yvec_t             seed_y_out,
    output xvec_t             centroids_x_out,
    output yvec_t             centroids_y_out,
    output logic              centroids_valid_out,
    output logic              busy_out,
    output logic [DROP_W-1:0] dropped_out,
    output logic              timeout_out
);

    localparam logic [YW-1:0] SEED_Y = YW'(HEIGHT / 2);

    seq_state_t        state_q, state_d;
    logic [NB_W-1:0]   nb_q, n_eff;
    logic              cold_q, cold_seed, load_seed, drop_evt, result_evt;
    xvec_t             seed_x_q, seed_x_d, cent_x_q, cold_x;
    yvec_t             seed_y_q, seed_y_d, cent_y_q;
    logic              cvalid_q, timeout_q, wd_expire;
    logic [DROP_W-1:0] dropped_q;
    logic [16:0]       wd_limit;

    kmeans_seed_rom #(
        .WIDTH (WIDTH)
    ) u_seed_rom (
        .n_i      (n_eff),
        .cold_x_o (cold_x)
    );

    assign n_eff      = (num_balls_in == '0) ? NB_W'(1) : num_balls_in;
    assign cold_seed  = cold_q | (n_eff != nb_q);
    assign load_seed  = (state_d == SEED) && (state_q != SEED);
    assign drop_evt   = frame_start_in && ((state_q == KICK) || (state_q == RUN));
    assign result_evt = (state_q == RUN) && km_valid_in;
    assign wd_limit   = 17'(TIMEOUT_CYCLES - 1);

`ifdef KMEANS_WATCHDOG_EN
    logic [16:0] wd_cnt_q;

    // Held at zero outside RUN so every RUN entry starts a fresh count.
    always_ff @(posedge clk_in) begin
        if (rst_in || (state_q != RUN)) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_q + 17'd1;
        end
    end

    assign wd_expire = (state_q == RUN) && !km_valid_in && (wd_cnt_q == wd_limit);
`else
    logic unused_wd_limit;
    assign unused_wd_limit = ^wd_limit;
    assign wd_expire       = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_start_in && enable_in) state_d = SEED;
            SEED:    state_d = STORE;
            STORE: begin
                if (frame_start_in) begin
                    state_d = SEED;
                end else if (frame_done_in) begin
                    state_d = KICK;
                end
            end
            KICK:    state_d = RUN;
            RUN:     if (km_valid_in || wd_expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        km_rst_out       = rst_in | (state_q == SEED) | timeout_q;
        km_new_frame_out = (state_q == KICK);
        busy_out         = (state_q != IDLE);
    end

    // Warm seeds reuse the last result; unused centroid slots are always zeroed.
    always_comb begin
        seed_x_d = '0;
        seed_y_d = '0;
        for (int i = 0; i < MAX_BALLS; i++) begin
            if (i < int'(n_eff)) begin
                seed_x_d[i] = cold_seed ? cold_x[i] : cent_x_q[i];
                seed_y_d[i] = cold_seed ? SEED_Y    : cent_y_q[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            nb_q      <= '0;
            cold_q    <= 1'b1;
            seed_x_q  <= '0;
            seed_y_q  <= '0;
            cent_x_q  <= '0;
            cent_y_q  <= '0;
            cvalid_q  <= 1'b0;
            timeout_q <= 1'b0;
            dropped_q <= '0;
        end else begin
            if (load_seed) begin
                seed_x_q <= seed_x_d;
                seed_y_q <= seed_y_d;
                nb_q     <= n_eff;
            end
            if (state_q == SEED) begin
                cold_q <= 1'b0;
            end else if (wd_expire) begin
                cold_q <= 1'b1;
            end
            if (result_evt) begin
                cent_x_q <= km_x_in;
                cent_y_q <= km_y_in;
            end
            cvalid_q  <= result_evt;
            timeout_q <= wd_expire;
            if (drop_evt && (dropped_q != '1)) begin
                dropped_q <= dropped_q + 1'b1;
            end
        end
    end

    assign seed_x_out          = seed_x_q;
    assign seed_y_out          = seed_y_q;
    assign centroids_x_out     = cent_x_q;
    assign centroids_y_out     = cent_y_q;
    assign centroids_valid_out = cvalid_q;
    assign dropped_out         = dropped_q;
    assign timeout_out         = timeout_q;

endmodule

// File: tb/tb_kmeans_frame_sequencer.sv
// Directed self-checking bench for kmeans_frame_sequencer with a result scoreboard.
module tb_kmeans_frame_sequencer;
    import kmeans_pkg::*;

`ifdef KMEANS_WATCHDOG_EN
    localparam int TB_TIMEOUT = 64;
    localparam int RUN_WAIT   = 40;
`else
    localparam int TB_TIMEOUT = 131072;
    localparam int RUN_WAIT   = 500;
`endif

    logic        clk = 1'b0;
    logic        rst, enable, frame_start, frame_done, km_valid;
    logic [2:0]  num_balls;
    xvec_t       km_x, seed_x, cent_x;
    yvec_t       km_y, seed_y, cent_y;
    logic        km_rst, km_new_frame, cvalid, busy, timeout;
    logic [7:0]  dropped;

    typedef struct packed {
        xvec_t x;
        yvec_t y;
    } result_t;

    result_t sb_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    kmeans_frame_sequencer #(
        .WIDTH          (320),
        .HEIGHT         (180),
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .DROP_W         (8)
    ) dut (
        .clk_in              (clk),
        .rst_in              (rst),
        .enable_in           (enable),
        .num_balls_in        (num_balls),
        .frame_start_in      (frame_start),
        .frame_done_in       (frame_done),
        .km_valid_in         (km_valid),
        .km_x_in             (km_x),
        .km_y_in             (km_y),
        .km_rst_out          (km_rst),
        .km_new_frame_out    (km_new_frame),
        .seed_x_out          (seed_x),
        .seed_y_out          (seed_y),
        .centroids_x_out     (cent_x),
        .centroids_y_out     (cent_y),
        .centroids_valid_out (cvalid),
        .busy_out            (busy),
        .dropped_out         (dropped),
        .timeout_out         (timeout)
    );

    function automatic xvec_t xv(input int a0, input int a1, input int a2);
        xvec_t v;
        v    = '0;
        v[0] = 9'(a0);
        v[1] = 9'(a1);
        v[2] = 9'(a2);
        return v;
    endfunction

    function automatic yvec_t yv(input int a0, input int a1, input int a2);
        yvec_t v;
        v    = '0;
        v[0] = 8'(a0);
        v[1] = 8'(a1);
        v[2] = 8'(a2);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves the DUT in SEED.
    task automatic start_frame(input logic [2:0] n);
        num_balls   = n;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // SEED -> STORE -> KICK -> RUN.
    task automatic finish_store();
        tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
    endtask

    task automatic expect_result(input string tag);
        result_t r;
        bit      seen;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (cvalid) seen = 1'b1;
            else tick();
        end
        chk({tag, "_valid_seen"}, 64'(seen), 64'(1));
        if (seen) begin
            chk({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                r = sb_q.pop_front();
                chk({tag, "_cent_x"}, 64'(cent_x), 64'(r.x));
                chk({tag, "_cent_y"}, 64'(cent_y), 64'(r.y));
            end
        end
    endtask

    task automatic deliver(input string tag, input xvec_t x, input yvec_t y);
        sb_q.push_back('{x: x, y: y});
        km_x     = x;
        km_y     = y;
        km_valid = 1'b1;
        tick();
        km_valid = 1'b0;
        expect_result(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int n;
        rst = 1'b1; enable = 1'b1; num_balls = 3'd2;
        frame_start = 1'b0; frame_done = 1'b0; km_valid = 1'b0;
        km_x = '0; km_y = '0;
        tick();
        tick();
        chk("rst_km_rst",    64'(km_rst),       64'(1));
        chk("rst_busy",      64'(busy),         64'(0));
        chk("rst_new_frame", 64'(km_new_frame), 64'(0));
        chk("rst_dropped",   64'(dropped),      64'(0));
        chk("rst_seed_x",    64'(seed_x),       64'(0));
        chk("rst_cent_x",    64'(cent_x),       64'(0));
        chk("rst_cvalid",    64'(cvalid),       64'(0));
        chk("rst_timeout",   64'(timeout),      64'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_km_rst", 64'(km_rst), 64'(0));

        enable = 1'b0;
        start_frame(3'd2);
        chk("disabled_busy",   64'(busy),   64'(0));
        chk("disabled_km_rst", 64'(km_rst), 64'(0));
        enable = 1'b1;

        // Cold start, n=2
        start_frame(3'd2);
        chk("cold2_km_rst", 64'(km_rst), 64'(1));
        chk("cold2_busy",   64'(busy),   64'(1));
        chk("cold2_seed_x", 64'(seed_x), 64'(xv(80, 240, 0)));
        chk("cold2_seed_y", 64'(seed_y), 64'(yv(90, 90, 0)));
        tick();
        chk("store_km_rst", 64'(km_rst), 64'(0));
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("kick_new_frame", 64'(km_new_frame), 64'(1));
        tick();
        chk("run_new_frame", 64'(km_new_frame), 64'(0));

        run_cycles(RUN_WAIT);
        chk("run_wait_busy", 64'(busy), 64'(1));
        deliver("res1", xv(100, 200, 77), yv(50, 60, 33));
        chk("res1_x0", 64'(cent_x[0]), 64'(100));
        chk("res1_busy", 64'(busy), 64'(0));
        tick();
        chk("res1_valid_drop", 64'(cvalid), 64'(0));

        // Warm start, same n: slot 2 must be zeroed
        start_frame(3'd2);
        chk("warm_seed_x", 64'(seed_x), 64'(xv(100, 200, 0)));
        chk("warm_seed_y", 64'(seed_y), 64'(yv(50, 60, 0)));
        finish_store();
        deliver("res2", xv(110, 210, 0), yv(55, 65, 0));

        start_frame(3'd3);
        chk("cold3_seed_x", 64'(seed_x), 64'(xv(53, 160, 266)));
        chk("cold3_seed_y", 64'(seed_y), 64'(yv(90, 90, 90)));
        finish_store();

        for (int i = 0; i < 3; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
        chk("drop3_count", 64'(dropped), 64'(3));
        chk("drop3_busy",  64'(busy),    64'(1));

        // Result and start on the same edge: latch, count, no restart
        sb_q.push_back('{x: xv(120, 220, 300), y: yv(10, 20, 30)});
        km_x = xv(120, 220, 300); km_y = yv(10, 20, 30);
        km_valid = 1'b1; frame_start = 1'b1;
        tick();
        km_valid = 1'b0; frame_start = 1'b0;
        chk("simul_dropped", 64'(dropped), 64'(4));
        chk("simul_busy",    64'(busy),    64'(0));
        chk("simul_km_rst",  64'(km_rst),  64'(0));
        expect_result("res3");

        // Start beats done in STORE
        start_frame(3'd3);
        chk("warm3_seed_x", 64'(seed_x), 64'(xv(120, 220, 300)));
        tick();
        frame_start = 1'b1; frame_done = 1'b1;
        tick();
        frame_start = 1'b0; frame_done = 1'b0;
        chk("store_race_km_rst",    64'(km_rst),       64'(1));
        chk("store_race_new_frame", 64'(km_new_frame), 64'(0));
        chk("store_race_dropped",   64'(dropped),      64'(4));
        tick();

        // Reset while in STORE
        rst = 1'b1;
        tick();
        chk("midrst_busy",    64'(busy),    64'(0));
        chk("midrst_km_rst",  64'(km_rst),  64'(1));
        chk("midrst_dropped", 64'(dropped), 64'(0));
        chk("midrst_cent_x",  64'(cent_x),  64'(0));
        chk("midrst_seed_x",  64'(seed_x),  64'(0));
        chk("midrst_cvalid",  64'(cvalid),  64'(0));
        rst = 1'b0;
        tick();
        chk("midrst_release_km_rst", 64'(km_rst), 64'(0));

        start_frame(3'd0);
        chk("n0_seed_x", 64'(seed_x), 64'(xv(160, 0, 0)));
        chk("n0_seed_y", 64'(seed_y), 64'(yv(90, 0, 0)));
        finish_store();
        deliver("res4", xv(150, 5, 5), yv(70, 5, 5));

        start_frame(3'd1);
        chk("warm1_seed_x", 64'(seed_x), 64'(xv(150, 0, 0)));
        finish_store();

`ifdef KMEANS_WATCHDOG_EN
        n = 0;
        while (!timeout && n < 200) begin
            tick();
            n++;
        end
        chk("wd_cycles",    64'(n),      64'(64));
        chk("wd_km_rst",    64'(km_rst), 64'(1));
        chk("wd_busy",      64'(busy),   64'(0));
        chk("wd_cvalid",    64'(cvalid), 64'(0));
        chk("wd_cent_x",    64'(cent_x), 64'(xv(150, 5, 5)));
        tick();
        chk("wd_pulse_end", 64'(timeout), 64'(0));
        start_frame(3'd1);
        chk("wd_cold_seed_x", 64'(seed_x), 64'(xv(160, 0, 0)));
        finish_store();
        deliver("res5", xv(1, 2, 3), yv(4, 5, 6));
`else
        n = 0;
        for (int i = 0; i < 300; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
            n++;
        end
        chk("drop_sat", 64'(dropped), 64'(255));
        run_cycles(1000);
        chk("nowd_busy",    64'(busy),    64'(1));
        chk("nowd_timeout", 64'(timeout), 64'(0));
        deliver("res5", xv(1, 2, 3), yv(4, 5, 6));
`endif

        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
